hazard_scoreboard: RTL
======================

# hazard_scoreboard

Producer side of the operand-forwarding path: tracks destination-register tags of in-flight instructions through EX and MM and drives the `ex_rd`/`mm_rd`/write-enable/`mm_is_load` tags consumed by every operand bypass mux. It detects load-use and long-latency (mul/div) hazards for the instruction in ID and raises `stall`. It keeps a per-register busy table for results written back outside the EX/MM path.

## Interface
Parameters:
- REG_NUM, 32, architectural register count; RW = $clog2(REG_NUM)
- LONG_MAX, 4, maximum outstanding long-latency ops (≥1)

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- id_valid  in  1  valid instruction in ID
- id_rs1, id_rs2  in  RW  source registers
- id_rs1_used, id_rs2_used  in  1  source actually read
- id_rd  in  RW  destination register
- id_wr_reg_en  in  1  instruction writes rd
- id_is_load  in  1  instruction is a load
- id_is_long  in  1  instruction is long-latency, result returns via long port
- flush  in  1  kill ID instruction and EX entry (redirect)
- long_done  in  1  long-latency result written to register file this cycle
- long_rd  in  RW  destination of that result
- ex_rd, mm_rd  out  RW  destination tags for bypass muxes
- ex_wr_reg_en, mm_wr_reg_en  out  1  tag valid for forwarding
- mm_is_load  out  1  MM entry is a load (forward memory data)
- stall  out  1  hold PC/IF/ID, inject bubble into EX
- issue  out  1  id_valid & ~stall & ~flush
- sb_err  out  1  sticky: long_done for a non-busy register, or busy-count underflow

## Operation
- Entry = {rd, wr_en, is_load}. EX and MM entries are registers. Pipeline advances every cycle; MM never back-pressures.
- Each cycle: MM ← EX. EX ← ID entry if `issue`, else bubble (all zero).
- The ID entry has wr_en = id_wr_reg_en & ~id_is_long & (id_rd != 0). x0 is never forwarded and never marked busy.
- Hazards on source s (rs1/rs2 with its used bit set, s != 0):
  - Load-use: EX.wr_en & EX.is_load & EX.rd == s.
  - Busy: busy[s] == 1.
- WAW: id_wr_reg_en & id_rd != 0 & busy[id_rd].
- Long structural: id_is_long & count == LONG_MAX.
- stall = id_valid & ~flush & (any hazard above).
- Issue of a long op (id_is_long & id_rd != 0) sets busy[id_rd] and increments count.
- long_done with busy[long_rd] == 1 clears busy[long_rd] and decrements count. With busy[long_rd] == 0 it is ignored and sets sb_err.
- Simultaneous long-op issue and valid long_done: count is unchanged, the set and the clear apply to their respective registers. WAW stall guarantees the two registers differ.
- flush: EX ← bubble, ID not issued, stall = 0. MM still takes the old EX contents. busy/count are untouched, because long ops already issued still complete.

## Timing
- Reset: ex_*, mm_* = 0; busy all 0; count 0; sb_err 0. Derived outputs: stall 0, issue = id_valid & ~flush.
- stall and issue are combinational from registered state and ID inputs. All other outputs are registered.
- A load-use stall lasts exactly 1 cycle. The load then sits in MM with mm_is_load = 1.
- Busy checks use registered busy bits with no same-cycle bypass of long_done. A dependent instruction issues the cycle after long_done, reading the register file.
- Reset asserted mid-operation clears all state immediately. Outstanding long results arriving after reset are ignored and set sb_err.

## Structure
- Package hazard_pkg: reg_idx_t (logic [RW-1:0]), fwd_entry_t struct {rd, wr_en, is_load}, BUBBLE constant.
- Sub-module sb_busy_table holds the REG_NUM busy bits and the outstanding counter:
  - inputs: set/set_rd, clr/clr_rd
  - outputs: busy vector, full, err
- Top level holds the EX/MM registers and the hazard compare logic.

## Test plan
- Load to x5 issued, next ID reads x5 → stall = 1 for one cycle. Next cycle mm_rd = 5, mm_is_load = 1, mm_wr_reg_en = 1, issue = 1.
- ALU write to x7, next ID reads x7 → no stall; ex_rd = 7, ex_wr_reg_en = 1. Following cycle mm_rd = 7, mm_is_load = 0.
- Long op writes x9, ID reads x9 → stall held until long_done (long_rd = 9). issue = 1 the cycle after; ex_wr_reg_en = 0 for the long op itself.
- With LONG_MAX = 4, issue long ops to x1..x4, then a fifth → stall. Fifth issues the cycle after one long_done. A simultaneous issue and done leave count unchanged.
- Load in EX, dependent in ID, flush asserted → stall = 0, issue = 0. Next cycle ex_wr_reg_en = 0; the old EX entry appears in MM.
- Writes to x0 and reads of x0 never cause stall or forwarding. long_done for x12 while not busy → sb_err = 1 and stays set until rst.

Source files
------------

// File: rtl/hazard_pkg.sv
`default_nettype none
// ============================================================================
// Module   : hazard_pkg
// Purpose  : Shared types for the forwarding/hazard scoreboard.
// Revision : 1.0  initial release
// ============================================================================
package hazard_pkg;

    localparam int DEF_REG_NUM  = 32;
    localparam int DEF_LONG_MAX = 4;
    localparam int RW           = $clog2(DEF_REG_NUM);

    typedef logic [RW-1:0] reg_idx_t;

    typedef struct packed {
        reg_idx_t rd;
        logic     wr_en;
        logic     is_load;
    } fwd_entry_t;

    localparam fwd_entry_t BUBBLE = '{rd: '0, wr_en: 1'b0, is_load: 1'b0};

    // A source only participates in hazard checks when it is read and not x0.
    function automatic logic src_live(input logic used, input reg_idx_t rs);
        return used && (rs != '0);
    endfunction

endpackage
`default_nettype wire

// File: rtl/sb_busy_table.sv
`default_nettype none
// ============================================================================
// Module   : sb_busy_table
// Purpose  : Per-register busy bits and outstanding count for long-latency ops.
// Revision : 1.0  initial release
// ============================================================================
module sb_busy_table
    import hazard_pkg::*;
#(
    parameter int REG_NUM  = DEF_REG_NUM,
    parameter int LONG_MAX = DEF_LONG_MAX
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       set,
    input  logic [$clog2(REG_NUM)-1:0] set_rd,
    input  logic                       clr,
    input  logic [$clog2(REG_NUM)-1:0] clr_rd,
    output logic [REG_NUM-1:0]         busy,
    output logic                       full,
    output logic                       err
);

    localparam int CW = $clog2(LONG_MAX + 1);

    logic [REG_NUM-1:0] r_busy;
    logic [REG_NUM-1:0] w_busy_nxt;
    logic [CW-1:0]      r_count;
    logic [CW-1:0]      w_count_nxt;
    logic               r_err;
    logic               w_clr_ok;
    logic               w_set_ok;
    logic               w_err_evt;

    always_comb begin
        w_clr_ok    = clr & r_busy[clr_rd];
        w_set_ok    = set & (set_rd != '0);
        w_err_evt   = clr & ~r_busy[clr_rd];
        w_busy_nxt  = r_busy;
        w_count_nxt = r_count;

        // Set and clear target different registers (WAW stall), so order is moot.
        if (w_clr_ok) w_busy_nxt[clr_rd] = 1'b0;
        if (w_set_ok) w_busy_nxt[set_rd] = 1'b1;

        case ({w_set_ok, w_clr_ok})
            2'b10:   w_count_nxt = r_count + CW'(1);
            2'b01: begin
                if (r_count == '0) w_err_evt   = 1'b1;
                else               w_count_nxt = r_count - CW'(1);
            end
            default: w_count_nxt = r_count;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_busy  <= '0;
            r_count <= '0;
            r_err   <= 1'b0;
        end else begin
            r_busy  <= w_busy_nxt;
            r_count <= w_count_nxt;
            r_err   <= r_err | w_err_evt;
        end
    end

    assign busy = r_busy;
    assign full = (r_count == CW'(LONG_MAX));
    assign err  = r_err;

endmodule
`default_nettype wire

// File: rtl/hazard_scoreboard.sv
`default_nettype none
// ============================================================================
// Module   : hazard_scoreboard
// Purpose  : EX/MM destination tags for bypass muxes plus load-use/long-op stall.
// Revision : 1.0  initial release
// ============================================================================
module hazard_scoreboard
    import hazard_pkg::*;
#(
    parameter int REG_NUM  = DEF_REG_NUM,
    parameter int LONG_MAX = DEF_LONG_MAX
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       id_valid,
    input  logic [$clog2(REG_NUM)-1:0] id_rs1,
    input  logic [$clog2(REG_NUM)-1:0] id_rs2,
    input  logic                       id_rs1_used,
    input  logic                       id_rs2_used,
    input  logic [$clog2(REG_NUM)-1:0] id_rd,
    input  logic                       id_wr_reg_en,
    input  logic                       id_is_load,
    input  logic                       id_is_long,
    input  logic                       flush,
    input  logic                       long_done,
    input  logic [$clog2(REG_NUM)-1:0] long_rd,
    output logic [$clog2(REG_NUM)-1:0] ex_rd,
    output logic [$clog2(REG_NUM)-1:0] mm_rd,
    output logic                       ex_wr_reg_en,
    output logic                       mm_wr_reg_en,
    output logic                       mm_is_load,
    output logic                       stall,
    output logic                       issue,
    output logic                       sb_err
);

    fwd_entry_t         r_ex;
    fwd_entry_t         r_mm;
    fwd_entry_t         w_id;
    logic [REG_NUM-1:0] w_busy;
    logic               w_full;
    logic               w_rs1_haz;
    logic               w_rs2_haz;
    logic               w_waw;
    logic               w_struct;
    logic               w_long_set;
    logic               w_ex_load;

    // Long ops retire through the long port, so they never forward from EX/MM.
    always_comb begin
        w_id         = BUBBLE;
        w_id.rd      = id_rd;
        w_id.wr_en   = id_wr_reg_en & ~id_is_long & (id_rd != '0);
        w_id.is_load = id_is_load;
    end

    assign w_ex_load = r_ex.wr_en & r_ex.is_load;

    assign w_rs1_haz = src_live(id_rs1_used, id_rs1) &
                       ((w_ex_load & (r_ex.rd == id_rs1)) | w_busy[id_rs1]);
    assign w_rs2_haz = src_live(id_rs2_used, id_rs2) &
                       ((w_ex_load & (r_ex.rd == id_rs2)) | w_busy[id_rs2]);
    assign w_waw     = id_wr_reg_en & (id_rd != '0) & w_busy[id_rd];
    assign w_struct  = id_is_long & w_full;

    assign stall = id_valid & ~flush & (w_rs1_haz | w_rs2_haz | w_waw | w_struct);
    assign issue = id_valid & ~stall & ~flush;

    assign w_long_set = issue & id_is_long;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ex <= BUBBLE;
            r_mm <= BUBBLE;
        end else begin
            r_mm <= r_ex;
            r_ex <= issue ? w_id : BUBBLE;
        end
    end

    sb_busy_table #(
        .REG_NUM  (REG_NUM),
        .LONG_MAX (LONG_MAX)
    ) u_busy_table (
        .clk    (clk),
        .rst    (rst),
        .set    (w_long_set),
        .set_rd (id_rd),
        .clr    (long_done),
        .clr_rd (long_rd),
        .busy   (w_busy),
        .full   (w_full),
        .err    (sb_err)
    );

    assign ex_rd        = r_ex.rd;
    assign ex_wr_reg_en = r_ex.wr_en;
    assign mm_rd        = r_mm.rd;
    assign mm_wr_reg_en = r_mm.wr_en;
    assign mm_is_load   = r_mm.is_load;

endmodule
`default_nettype wire
